// File: rtl/main_memory.sv
// main_memory: 2**ADDR_W x 32-bit word store with a fixed access latency.
// Serves cache block refills (four words read as one block) and single-word
// write-through stores, one request at a time.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; also clears every word
//   RdReq        block read request (wins over WrReq when both are high)
//   WrReq        single word write request
//   WordAddress  word address; bits [1:0] are ignored for block reads
//   WrData       write data
//   RdBlock      last block read; word offset 0 in [31:0], offset 3 in [127:96]
//   Ready        one-cycle completion pulse, LATENCY edges after acceptance
//   Busy         high whenever the FSM is not in IDLE (includes the Ready cycle)
module main_memory #(
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RdReq,
    input  logic                      WrReq,
    input  logic [ADDR_W-1:0]         WordAddress,
    input  logic [31:0]               WrData,
    output logic [32*BLOCK_WORDS-1:0] RdBlock,
    output logic                      Ready,
    output logic                      Busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state, nextState;
    logic [3:0]         counter;
    logic [ADDR_W-3:0]  blockAddr;
    logic [ADDR_W-1:0]  wrAddr;
    logic [31:0]        wrDataHeld;
    logic [31:0]        mem [DEPTH];
    logic               finish;

    // The access happens on the edge where the countdown has reached zero.
    always_comb begin
        nextState = state;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (RdReq)      nextState = READ;
                else if (WrReq) nextState = WRITE;
            end
            READ, WRITE: begin
                if (counter == 4'd0) begin
                    finish    = 1'b1;
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            Ready   <= 1'b0;
            RdBlock <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Ready is only ever high for the edge that completes an access.
            Ready <= finish;
            unique case (state)
                IDLE: begin
                    if (RdReq) begin
                        blockAddr <= WordAddress[ADDR_W-1:2];
                        counter   <= 4'(LATENCY - 1);
                    end else if (WrReq) begin
                        wrAddr     <= WordAddress;
                        wrDataHeld <= WrData;
                        counter    <= 4'(LATENCY - 1);
                    end
                end
                READ: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
                            RdBlock[32*i +: 32] <= mem[{blockAddr, i[1:0]}];
                        end
                    end
                end
                WRITE: begin
                    if (counter != 4'd0) counter <= counter - 4'd1;
                    else                 mem[wrAddr] <= wrDataHeld;
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state != IDLE);

endmodule
